mem_bist_master: RTL and testbench
==================================

Name: mem_bist_master

Overview:
- Initiator for the team's SRAM valid/ready interface; drives the SRAM block's `valid_i`, `wr_rd_en_i`, `addr_i` and `wdata_i`, and consumes its `ready_o` and `rdata_o`.
- On a start pulse it writes a deterministic pattern to every address, then reads each address back and compares.
- Reports pass/fail, error count and first failing address.
- Sits beside each SRAM instance as a built-in self-test / bring-up engine.

Parameters:
- DEPTH, 16, number of SRAM words.
- WIDTH, 8, SRAM data width.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- SEED, 8'hA5, pattern seed, truncated or zero-extended to WIDTH.
- TIMEOUT, 64, maximum cycles to wait for ready_i per transaction; used only with the optional feature.

Ports:
- clk_i  input  1  clock, rising edge.
- clr_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  single-cycle start pulse.
- valid_o  output  1  request valid, to the SRAM's valid_i.
- wr_rd_en_o  output  1  1 = write, 0 = read.
- addr_o  output  ADDR_WIDTH  request address.
- wdata_o  output  WIDTH  write data.
- ready_i  input  1  SRAM ready.
- rdata_i  input  WIDTH  SRAM read data.
- busy_o  output  1  test in progress.
- done_o  output  1  test finished; held until the next start.
- pass_o  output  1  no mismatches and no timeout; valid when done_o=1.
- err_count_o  output  ADDR_WIDTH+1  number of mismatching words.
- first_fail_addr_o  output  ADDR_WIDTH  address of the first mismatch.
- timeout_o  output  1  test aborted on a ready timeout.

Behaviour:
- All outputs are registered. On clr_i assertion, every output and all internal state go to 0 and the FSM goes to IDLE, regardless of the current state or any in-flight transaction.
- pattern(a) = {zero-extended a} XOR SEED, taken in WIDTH bits.
- FSM states: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
- IDLE / DONE:
  - start_i=1 clears done_o, pass_o, err_count_o, first_fail_addr_o and timeout_o.
  - Sets addr=0 and busy_o=1, then goes to WR_REQ.
  - start_i while in any busy state is ignored.
- WR_REQ:
  - Drives valid_o=1, wr_rd_en_o=1, addr_o=addr, wdata_o=pattern(addr).
  - Holds all request signals stable until ready_i=1 is sampled, then goes to WR_GAP with valid_o=0.
- WR_GAP:
  - valid_o=0. Waits until ready_i=0 is sampled.
  - Then, if addr==DEPTH-1: addr=0 and go to RD_REQ. Otherwise: addr+1 and go back to WR_REQ.
  - The gap is mandatory because the responder holds ready high and repeats the operation while valid is high. A repeated write of identical data is harmless.
- RD_REQ:
  - Drives valid_o=1, wr_rd_en_o=0, addr_o=addr, wdata_o=0.
  - On the cycle ready_i=1 is sampled, captures rdata_i and compares it with pattern(addr).
  - On a mismatch: err_count_o increments; if this is the first mismatch, first_fail_addr_o=addr.
  - Then goes to RD_GAP.
- RD_GAP:
  - Waits until ready_i=0 is sampled.
  - Then, if addr==DEPTH-1: go to DONE. Otherwise: addr+1 and go back to RD_REQ.
- Entering DONE: busy_o=0, done_o=1, pass_o=(err_count==0 && !timeout).
- Timing: with the zero-wait SRAM responder, each transaction takes 4 cycles. Total start-to-done is 8·DEPTH cycles, ±2.
- err_count_o cannot overflow (maximum value DEPTH).
- A ready_i glitch while the FSM is in IDLE or DONE is ignored.

Optional Feature:
- Macro: MEM_BIST_TIMEOUT_EN.
- Defined:
  - A per-transaction counter runs in WR_REQ and RD_REQ and in both GAP states; it resets on every state change.
  - When the counter reaches TIMEOUT: valid_o=0, timeout_o=1, pass_o=0, and the FSM goes to DONE.
- Not defined:
  - No counter is built and timeout_o is tied to 0.
  - The FSM waits indefinitely for the handshake.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum typedef bist_state_t;
  - the default DEPTH/WIDTH/SEED constants;
  - the pattern function pattern_f(addr).
- The SRAM block and the bench import the same package.
- One natural sub-module: mem_bist_cmp, the registered compare plus error-count and first-fail capture.

Test Plan (all with DEPTH=16, WIDTH=8, SEED=8'hA5, connected to the SRAM block):
- Clean run: start_i pulse → 16 writes (addr 3 gets data 8'hA6), then 16 reads. done_o=1 within 130 cycles; pass_o=1; err_count_o=0.
- Fault injection: bench backdoor-writes mem[5]=8'h00 between the write and read phases → err_count_o=1, first_fail_addr_o=5, pass_o=0.
- Two faults, at addr 9 and addr 2 → err_count_o=2, first_fail_addr_o=2.
- Reset mid-run: assert clr_i during read of addr 7 → all outputs 0 immediately (asynchronous). A subsequent start_i gives a full clean pass.
- start_i repeated while busy_o=1 → ignored; completion time is unchanged. start_i after done → results clear and the run repeats.
- With MEM_BIST_TIMEOUT_EN, responder ready forced to 0 → after 64 cycles: timeout_o=1, done_o=1, pass_o=0, valid_o=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared SRAM/BIST package: FSM state type, default geometry and the test pattern.
package mem_pkg;

  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned WIDTH_DEF = 8;
  localparam logic [31:0] SEED_DEF  = 32'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_GAP = 3'd2,
    RD_REQ = 3'd3,
    RD_GAP = 3'd4,
    DONE   = 3'd5
  } bist_state_t;

  // Callers truncate the result to their data width.
  function automatic logic [31:0] pattern_f(input logic [31:0] addr,
                                            input logic [31:0] seed = SEED_DEF);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-back checker: compares returned data with the pattern, counts mismatches
// and latches the address of the first one.
module mem_bist_cmp
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter logic [31:0] SEED       = SEED_DEF
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      rdata_i,
  output logic [ADDR_WIDTH:0]   err_count_o,
  output logic [ADDR_WIDTH-1:0] first_fail_addr_o
);

  logic [WIDTH-1:0]      exp_c;
  logic                  mismatch_c;
  logic [ADDR_WIDTH:0]   err_count_q;
  logic [ADDR_WIDTH-1:0] first_fail_q;

  assign exp_c      = WIDTH'(pattern_f(32'(addr_i), SEED));
  assign mismatch_c = en_i && (rdata_i != exp_c);

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      err_count_q  <= '0;
      first_fail_q <= '0;
    end else if (clear_i) begin
      err_count_q  <= '0;
      first_fail_q <= '0;
    end else if (mismatch_c) begin
      err_count_q <= err_count_q + (ADDR_WIDTH+1)'(1);
      if (err_count_q == '0) first_fail_q <= addr_i;
    end
  end

  assign err_count_o       = err_count_q;
  assign first_fail_addr_o = first_fail_q;

endmodule

// File: rtl/mem_bist_master.sv
// March-style write-then-read BIST initiator for the SRAM valid/ready port.
// Optional per-transaction ready timeout: define MEM_BIST_TIMEOUT_EN.
module mem_bist_master
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [31:0] SEED       = SEED_DEF,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  start_i,
  output logic                  valid_o,
  output logic                  wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  input  logic                  ready_i,
  input  logic [WIDTH-1:0]      rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH:0]   err_count_o,
  output logic [ADDR_WIDTH-1:0] first_fail_addr_o,
  output logic                  timeout_o
);

  bist_state_t           state_q;
  logic                  valid_q, wr_q, busy_q, done_q, pass_q, timeout_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  last_c, start_acc_c, cmp_en_c, tmo_hit_c;
  logic [ADDR_WIDTH:0]   err_count_c;

  function automatic logic [WIDTH-1:0] pat_f(input logic [ADDR_WIDTH-1:0] a);
    return WIDTH'(pattern_f(32'(a), SEED));
  endfunction

  assign last_c      = (addr_q == ADDR_WIDTH'(DEPTH - 1));
  assign start_acc_c = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign cmp_en_c    = (state_q == RD_REQ) && ready_i;

`ifdef MEM_BIST_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic             busy_state_c, advance_c;
  logic [TMO_W-1:0] tmo_cnt_q;

  assign busy_state_c = (state_q == WR_REQ) || (state_q == WR_GAP) ||
                        (state_q == RD_REQ) || (state_q == RD_GAP);
  assign advance_c    = ((state_q == WR_REQ) || (state_q == RD_REQ)) ? ready_i :
                        ((state_q == WR_GAP) || (state_q == RD_GAP)) ? !ready_i : 1'b0;
  assign tmo_hit_c    = busy_state_c && !advance_c && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

  // Restarts on every state change so each handshake phase gets the full budget.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i)                           tmo_cnt_q <= '0;
    else if (!busy_state_c || advance_c) tmo_cnt_q <= '0;
    else                                 tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
  end
`else
  logic unused_tmo_c;
  assign tmo_hit_c    = 1'b0;
  assign unused_tmo_c = ^32'(TIMEOUT);
`endif

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (tmo_hit_c) begin
      state_q   <= DONE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b1;
      pass_q    <= 1'b0;
      timeout_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q   <= WR_REQ;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            addr_q    <= '0;
            valid_q   <= 1'b1;
            wr_q      <= 1'b1;
            wdata_q   <= pat_f('0);
          end
        end
        WR_REQ: begin
          if (ready_i) begin
            state_q <= WR_GAP;
            valid_q <= 1'b0;
          end
        end
        // Responder repeats while valid is high, so wait for ready to drop.
        WR_GAP: begin
          if (!ready_i) begin
            valid_q <= 1'b1;
            if (last_c) begin
              state_q <= RD_REQ;
              addr_q  <= '0;
              wr_q    <= 1'b0;
              wdata_q <= '0;
            end else begin
              state_q <= WR_REQ;
              addr_q  <= addr_q + ADDR_WIDTH'(1);
              wr_q    <= 1'b1;
              wdata_q <= pat_f(addr_q + ADDR_WIDTH'(1));
            end
          end
        end
        RD_REQ: begin
          if (ready_i) begin
            state_q <= RD_GAP;
            valid_q <= 1'b0;
          end
        end
        RD_GAP: begin
          if (!ready_i) begin
            if (last_c) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_c == '0) && !timeout_q;
            end else begin
              state_q <= RD_REQ;
              addr_q  <= addr_q + ADDR_WIDTH'(1);
              valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_bist_cmp #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEED       (SEED)
  ) u_cmp (
    .clk_i             (clk_i),
    .clr_i             (clr_i),
    .clear_i           (start_acc_c),
    .en_i              (cmp_en_c),
    .addr_i            (addr_q),
    .rdata_i           (rdata_i),
    .err_count_o       (err_count_c),
    .first_fail_addr_o (first_fail_addr_o)
  );

  assign valid_o     = valid_q;
  assign wr_rd_en_o  = wr_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign err_count_o = err_count_c;

endmodule

// File: tb/tb_mem_bist_master.sv
// Directed bench for mem_bist_master against a zero-wait SRAM responder model with backdoor fault injection.
module tb_mem_bist_master;
  import mem_pkg::*;

  logic       clk, clr, start;
  logic       valid, wr, rdy, busy, done, pass, tmo;
  logic [3:0] addr, ffa;
  logic [7:0] wdata, rdata;
  logic [4:0] err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc, cyc_ref;

  logic [7:0] mem [16];
  logic [7:0] wr3_data;
  logic       force_nrdy, bd_en;
  logic [3:0] bd_addr;

  mem_bist_master dut (
    .clk_i             (clk),
    .clr_i             (clr),
    .start_i           (start),
    .valid_o           (valid),
    .wr_rd_en_o        (wr),
    .addr_o            (addr),
    .wdata_o           (wdata),
    .ready_i           (rdy),
    .rdata_i           (rdata),
    .busy_o            (busy),
    .done_o            (done),
    .pass_o            (pass),
    .err_count_o       (err),
    .first_fail_addr_o (ffa),
    .timeout_o         (tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Zero-wait responder: ready follows valid by one cycle; repeats while valid stays high.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      rdy   <= 1'b0;
      rdata <= 8'h00;
    end else begin
      rdy <= valid && !force_nrdy;
      if (valid && wr) begin
        mem[addr] <= wdata;
        if (addr == 4'd3) wr3_data <= wdata;
      end else if (valid) begin
        rdata <= mem[addr];
      end
      if (bd_en) mem[bd_addr] <= 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_bist(input int nf, input logic [3:0] fa0, input logic [3:0] fa1,
                          input bit spam, output int cycles);
    int injected = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("start_valid", 32'(valid), 32'd1);
    check("start_wr",    32'(wr),    32'd1);
    check("start_addr",  32'(addr),  32'd0);
    check("start_wdata", 32'(wdata), 32'hA5);
    check("start_busy",  32'(busy),  32'd1);
    check("start_done",  32'(done),  32'd0);
    check("start_err",   32'(err),   32'd0);
    check("start_ffa",   32'(ffa),   32'd0);
    cycles = 0;
    while (!done && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
      start = spam && (cycles == 10 || cycles == 70);
      if (valid && !wr && injected < nf) begin
        bd_en   = 1'b1;
        bd_addr = (injected == 0) ? fa0 : fa1;
        injected++;
      end else begin
        bd_en = 1'b0;
      end
    end
    start = 1'b0;
    bd_en = 1'b0;
    if (cycles >= 300) check("done_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; force_nrdy = 1'b0; bd_en = 1'b0; bd_addr = 4'd0;
    wr3_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_pass",  32'(pass),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_tmo",   32'(tmo),   32'd0);
    @(negedge clk) clr = 1'b0;

    // Clean run: 32 transactions x 4 cycles after the start edge.
    run_bist(0, 4'd0, 4'd0, 1'b0, cyc);
    cyc_ref = cyc;
    check("clean_done",   32'(done), 32'd1);
    check("clean_pass",   32'(pass), 32'd1);
    check("clean_err",    32'(err),  32'd0);
    check("clean_busy",   32'(busy), 32'd0);
    check("clean_tmo",    32'(tmo),  32'd0);
    check("clean_wr3",    32'(wr3_data), 32'hA6);
    check("clean_cycles", 32'(cyc >= 126 && cyc <= 130), 32'd1);

    // Idle ready glitch must not disturb the results.
    @(negedge clk) force rdy = 1'b1;
    @(negedge clk) release rdy;
    check("glitch_done", 32'(done), 32'd1);
    check("glitch_pass", 32'(pass), 32'd1);

    run_bist(1, 4'd5, 4'd0, 1'b0, cyc);
    check("f1_err",  32'(err),  32'd1);
    check("f1_ffa",  32'(ffa),  32'd5);
    check("f1_pass", 32'(pass), 32'd0);
    check("f1_done", 32'(done), 32'd1);

    run_bist(2, 4'd9, 4'd2, 1'b0, cyc);
    check("f2_err",  32'(err),  32'd2);
    check("f2_ffa",  32'(ffa),  32'd2);
    check("f2_pass", 32'(pass), 32'd0);

    // Restart after a failing run clears results; spurious starts while busy are ignored.
    run_bist(0, 4'd0, 4'd0, 1'b1, cyc);
    check("spam_pass",   32'(pass), 32'd1);
    check("spam_err",    32'(err),  32'd0);
    check("spam_ffa",    32'(ffa),  32'd0);
    check("spam_cycles", 32'(cyc),  32'(cyc_ref));

    // Asynchronous clear during the read of address 7.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!(valid && !wr && addr == 4'd7) && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rd7_reached", 32'(cyc < 300), 32'd1);
    #2 clr = 1'b1;
    #1;
    check("clr_valid", 32'(valid), 32'd0);
    check("clr_wr",    32'(wr),    32'd0);
    check("clr_addr",  32'(addr),  32'd0);
    check("clr_busy",  32'(busy),  32'd0);
    check("clr_done",  32'(done),  32'd0);
    check("clr_pass",  32'(pass),  32'd0);
    check("clr_err",   32'(err),   32'd0);
    check("clr_tmo",   32'(tmo),   32'd0);
    @(negedge clk) clr = 1'b0;
    run_bist(0, 4'd0, 4'd0, 1'b0, cyc);
    check("post_clr_pass", 32'(pass), 32'd1);
    check("post_clr_err",  32'(err),  32'd0);

`ifdef MEM_BIST_TIMEOUT_EN
    force_nrdy = 1'b1;
    run_bist(0, 4'd0, 4'd0, 1'b0, cyc);
    force_nrdy = 1'b0;
    check("tmo_flag",   32'(tmo),   32'd1);
    check("tmo_done",   32'(done),  32'd1);
    check("tmo_pass",   32'(pass),  32'd0);
    check("tmo_valid",  32'(valid), 32'd0);
    check("tmo_cycles", 32'(cyc),   32'd64);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
